bounce_generator: RTL and testbench
===================================

// Module: bounce_generator
// PURPOSE
//   Switch-bounce emulator: the transmit side of the button path into debouncer_fsm.
//   Accepts a clean target switch level over a valid/ready command port.
//   Drives sw_out with an LFSR-randomised burst of toggles for a fixed window, then settles at the target.
//   Used on-board and in benches to exercise debouncer_fsm and the press counter without a physical button.
// PARAMETERS
//   BOUNCE_CYCLES  1_000_000  bounce window length in clk cycles (10 ms @ 100 MHz); legal values >= 1
//   MAX_GAP_W      8          width of the random toggle gap; gap range 1..2**MAX_GAP_W cycles
//   LFSR_SEED      16'hACE1   LFSR reset value; must be non-zero
//   IDLE_LEVEL     1'b0       sw_out value after reset (switch released)
// PORTS
//   clk         in   1   system clock; all logic on posedge
//   reset       in   1   synchronous, active-high reset
//   cmd_valid   in   1   command request
//   cmd_level   in   1   target settled switch level
//   cmd_ready   out  1   high when idle and able to accept a command
//   sw_out      out  1   emulated raw switch signal; connects to debouncer_fsm sw
//   busy        out  1   high while bouncing
//   done        out  1   one-cycle pulse when sw_out has settled at the target
//   toggle_cnt  out  16  sw_out edges produced by the last command; saturates at 16'hFFFF
// BEHAVIOUR
//   Reset (sync, all outputs registered):
//     - state=IDLE, sw_out=IDLE_LEVEL, cmd_ready=1, busy=0, done=0, toggle_cnt=0, lfsr=LFSR_SEED.
//     - Reset mid-bounce aborts the burst; the next cycle is a clean IDLE. No done pulse is produced.
//   Handshake: a command is accepted on a cycle with cmd_valid && cmd_ready (cycle t).
//     - cmd_ready=0 outside IDLE. cmd_valid is ignored there and commands are not queued.
//   FSM states: IDLE, BOUNCE, SETTLE.
//   IDLE, on accept with cmd_level == sw_out:
//     - Stay in IDLE; no edges.
//     - done=1 and toggle_cnt=0 at t+1.
//   IDLE, on accept with cmd_level != sw_out:
//     - At t+1: sw_out toggles (the first edge), toggle_cnt=1, state goes to BOUNCE, busy=1, cmd_ready=0.
//     - The target is latched, and win_cnt loads BOUNCE_CYCLES-1.
//     - gap_cnt loads lfsr[MAX_GAP_W-1:0]+1 and the LFSR advances.
//   BOUNCE, every cycle:
//     - win_cnt decrements.
//     - When gap_cnt==1: sw_out toggles, toggle_cnt increments (saturating), gap_cnt reloads from the LFSR, and the LFSR advances.
//     - Otherwise gap_cnt decrements.
//     - When win_cnt==0, go to SETTLE instead; no toggle occurs on that cycle.
//   SETTLE, one cycle:
//     - sw_out is forced to the latched target regardless of toggle parity; a parity correction counts as an edge.
//     - Next cycle: IDLE, done=1 for 1 cycle, busy=0, cmd_ready=1.
//   Timing: accept at t -> done at t+BOUNCE_CYCLES+2; sw_out is stable from t+BOUNCE_CYCLES+1 onward.
//   LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. It advances only on gap loads, so sequences are deterministic per seed.
//   Widths:
//     - win_cnt is $clog2(BOUNCE_CYCLES+1) bits; gap_cnt is MAX_GAP_W+1 bits (holds 2**MAX_GAP_W).
//   Boundary cases:
//     - BOUNCE_CYCLES=1: exactly one toggle, then SETTLE.
//     - A gap reload and window expiry in the same cycle: expiry wins.
//     - cmd_valid held high: the next command is accepted in the same cycle that done pulses.
// TESTING (bench params: BOUNCE_CYCLES=20, MAX_GAP_W=2, LFSR_SEED=16'hACE1)
//   1. Reset -> sw_out=0, cmd_ready=1, busy=0, done=0, toggle_cnt=0; hold reset 3 cycles mid-bounce -> same values, no done.
//   2. cmd_level=1 accepted at t -> sw_out=1 at t+1, busy over t+1..t+21, done only at t+22, sw_out=1 from t+21.
//   3. Same as 2 -> gap between edges always 1..4 cycles; toggle_cnt equals counted edges; edge sequence matches golden LFSR model.
//   4. cmd_level equal to current sw_out -> no edges, done at t+1, toggle_cnt=0.
//   5. cmd_valid pulses while busy -> ignored, no extra done; cmd_valid held high -> back-to-back 1,0 commands, second accepted on first done cycle.
//   6. Drive debouncer_fsm with sw_out, 10 press/release pairs -> press counter reads 10, sw_out glitch-free after each done.

Source files
------------

// File: rtl/bounce_generator.sv
// Switch-bounce emulator: accepts a target switch level and drives sw_out with an
// LFSR-randomised burst of toggles for a fixed window before settling at the target.
module bounce_generator #(
   parameter int unsigned BOUNCE_CYCLES = 1_000_000,
   parameter int unsigned MAX_GAP_W     = 8,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
   parameter logic        IDLE_LEVEL    = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   input  logic        cmd_level,
   output logic        cmd_ready,
   output logic        sw_out,
   output logic        busy,
   output logic        done,
   output logic [15:0] toggle_cnt
);

   localparam int unsigned WIN_W = $clog2(BOUNCE_CYCLES + 1);
   localparam int unsigned GAP_W = MAX_GAP_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      BOUNCE,
      SETTLE
   } state_t;

   state_t             state;
   logic [WIN_W-1:0]   win_cnt;
   logic [GAP_W-1:0]   gap_cnt;
   logic [15:0]        lfsr;
   logic               target;
   logic [GAP_W-1:0]   gap_load;
   logic [15:0]        lfsr_adv;
   logic [15:0]        toggle_inc;

   // Galois form of x^16+x^14+x^13+x^11+1
   always_comb begin
      lfsr_adv = {1'b0, lfsr[15:1]};
      if (lfsr[0]) begin
         lfsr_adv = lfsr_adv ^ 16'hB400;
      end
      gap_load   = GAP_W'(lfsr[MAX_GAP_W-1:0]) + GAP_W'(1);
      toggle_inc = (toggle_cnt == '1) ? toggle_cnt : toggle_cnt + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         sw_out     <= IDLE_LEVEL;
         cmd_ready  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         toggle_cnt <= '0;
         lfsr       <= LFSR_SEED;
         win_cnt    <= '0;
         gap_cnt    <= '0;
         target     <= IDLE_LEVEL;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  if (cmd_level == sw_out) begin
                     done       <= 1'b1;
                     toggle_cnt <= '0;
                  end else begin
                     state      <= BOUNCE;
                     sw_out     <= ~sw_out;
                     toggle_cnt <= 16'd1;
                     busy       <= 1'b1;
                     cmd_ready  <= 1'b0;
                     target     <= cmd_level;
                     win_cnt    <= WIN_W'(BOUNCE_CYCLES - 1);
                     gap_cnt    <= gap_load;
                     lfsr       <= lfsr_adv;
                  end
               end
            end
            BOUNCE: begin
               // The target is forced on entry to SETTLE so sw_out is stable a cycle before done.
               if (win_cnt == '0) begin
                  state <= SETTLE;
                  if (sw_out != target) begin
                     sw_out     <= target;
                     toggle_cnt <= toggle_inc;
                  end
               end else begin
                  win_cnt <= win_cnt - WIN_W'(1);
                  if (gap_cnt == GAP_W'(1)) begin
                     sw_out     <= ~sw_out;
                     toggle_cnt <= toggle_inc;
                     gap_cnt    <= gap_load;
                     lfsr       <= lfsr_adv;
                  end else begin
                     gap_cnt <= gap_cnt - GAP_W'(1);
                  end
               end
            end
            SETTLE: begin
               state     <= IDLE;
               done      <= 1'b1;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bounce_generator.sv
// Self-checking bench for bounce_generator: randomized commands against an edge-schedule
// reference model derived from the LFSR polynomial and window/gap rules.
module tb_bounce_generator;

   localparam int unsigned BC   = 20;
   localparam int unsigned GW   = 2;
   localparam logic [15:0] SEED = 16'hACE1;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_level;
   logic        cmd_ready;
   logic        sw_out;
   logic        busy;
   logic        done;
   logic [15:0] toggle_cnt;

   int tests = 0;
   int fails = 0;

   logic [15:0] m_lfsr;
   logic        m_sw;

   bit   press_en = 1'b0;
   logic db_level = 1'b0;
   int   db_run   = 0;
   int   press_cnt = 0;

   bounce_generator #(
      .BOUNCE_CYCLES(BC),
      .MAX_GAP_W    (GW),
      .LFSR_SEED    (SEED),
      .IDLE_LEVEL   (1'b0)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_level (cmd_level),
      .cmd_ready (cmd_ready),
      .sw_out    (sw_out),
      .busy      (busy),
      .done      (done),
      .toggle_cnt(toggle_cnt)
   );

   always #5 clk = ~clk;

   // Simple debouncer + press counter: a level is accepted after 6 stable samples.
   always @(negedge clk) begin
      if (sw_out === db_level) begin
         db_run = 0;
      end else begin
         db_run = db_run + 1;
         if (db_run == 6) begin
            db_level = sw_out;
            db_run   = 0;
            if (db_level && press_en) press_cnt = press_cnt + 1;
         end
      end
   end

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      logic [16:0] poly;
      poly = 17'h16801;   // x^16+x^14+x^13+x^11+1, taps folded onto the right shift
      if (s[0]) return (s >> 1) ^ poly[16:1];
      return s >> 1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_cmd(input logic lvl, input bit hold, input logic nxt);
      int edges[$];
      int e;
      int cnt;
      logic exp_sw;
      cmd_valid = 1'b1;
      cmd_level = lvl;
      tick();
      if (!hold) cmd_valid = 1'b0;
      if (lvl == m_sw) begin
         chk("eq_done", done, 1);
         chk("eq_cnt", toggle_cnt, 0);
         chk("eq_sw", sw_out, m_sw);
         chk("eq_busy", busy, 0);
         if (hold) begin
            cmd_level = nxt;
         end else begin
            tick();
            chk("eq_done_clr", done, 0);
         end
         return;
      end
      e = 1;
      do begin
         edges.push_back(e);
         e = e + int'(m_lfsr % (16'd1 << GW)) + 1;
         m_lfsr = lfsr_step(m_lfsr);
      end while (e <= int'(BC));
      for (int r = 1; r <= int'(BC) + 1; r++) begin
         if (r > 1) tick();
         if (!hold) begin
            cmd_valid = (r == int'(BC) + 1) ? 1'b0 : 1'($urandom_range(0, 1));
            cmd_level = 1'($urandom);
         end else if (r == int'(BC) + 1) begin
            cmd_level = nxt;
         end
         cnt = 0;
         foreach (edges[i]) if (edges[i] <= r) cnt++;
         exp_sw = m_sw ^ cnt[0];
         if (r == int'(BC) + 1 && exp_sw != lvl) begin
            exp_sw = lvl;
            cnt++;
         end
         chk($sformatf("b_sw_r%0d", r), sw_out, exp_sw);
         chk($sformatf("b_cnt_r%0d", r), toggle_cnt, cnt);
         chk($sformatf("b_busy_r%0d", r), busy, 1);
         chk($sformatf("b_done_r%0d", r), done, 0);
         chk($sformatf("b_rdy_r%0d", r), cmd_ready, 0);
      end
      tick();
      chk("d_done", done, 1);
      chk("d_busy", busy, 0);
      chk("d_rdy", cmd_ready, 1);
      chk("d_sw", sw_out, lvl);
      chk("d_cnt", toggle_cnt, cnt);
      m_sw = lvl;
      if (hold) begin
         cmd_level = nxt;
      end else begin
         tick();
         chk("post_done", done, 0);
         chk("post_sw", sw_out, lvl);
      end
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_level = 1'b0;
      m_lfsr    = SEED;
      m_sw      = 1'b0;
      tick();
      tick();
      chk("rst_sw", sw_out, 0);
      chk("rst_rdy", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cnt", toggle_cnt, 0);
      reset = 1'b0;
      tick();

      do_cmd(1'b1, 1'b0, 1'b0);
      do_cmd(1'b1, 1'b0, 1'b0);
      do_cmd(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) do_cmd(1'($urandom), 1'b0, 1'b0);

      // reset held for three cycles in the middle of a burst
      cmd_valid = 1'b1;
      cmd_level = ~m_sw;
      tick();
      cmd_valid = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("mid_busy", busy, 1);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("mr_sw", sw_out, 0);
         chk("mr_rdy", cmd_ready, 1);
         chk("mr_busy", busy, 0);
         chk("mr_done", done, 0);
         chk("mr_cnt", toggle_cnt, 0);
      end
      reset = 1'b0;
      m_lfsr = SEED;
      m_sw   = 1'b0;
      for (int k = 0; k < int'(BC) + 4; k++) begin
         tick();
         chk("ar_done", done, 0);
         chk("ar_sw", sw_out, 0);
      end

      // cmd_valid held high: back-to-back commands accepted on each done cycle
      do_cmd(1'b1, 1'b1, 1'b0);
      do_cmd(1'b0, 1'b1, 1'b0);
      do_cmd(1'b0, 1'b1, 1'b1);
      do_cmd(1'b1, 1'b0, 1'b0);

      do_cmd(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) tick();
      press_en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         do_cmd(1'b1, 1'b0, 1'b0);
         for (int j = 0; j < 8; j++) begin
            tick();
            chk("rel_stable", sw_out, 1);
         end
         do_cmd(1'b0, 1'b0, 1'b0);
         for (int j = 0; j < 8; j++) begin
            tick();
            chk("prs_stable", sw_out, 0);
         end
      end
      press_en = 1'b0;
      chk("press_count", press_cnt, 10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
